// File: rtl/vmx_sched_if.sv
// Bundles the command, engine and BRAM handshake signals of vmx_tile_scheduler.
//  master : scheduler side (drives cmd_ready, eng_ctrl, mem_addr, mem_wr_en, host_gnt)
//  slave  : PS register file / engine / host side (drives the remaining signals)
interface vmx_sched_if #(
    parameter int unsigned MAX_TILES  = 16,
    parameter int unsigned ADDR_WIDTH = 12
) ();
    localparam int unsigned TW = $clog2(MAX_TILES) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [TW-1:0]         cmd_tiles;
    logic                  cmd_simd;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [31:0]           eng_ctrl;
    logic [31:0]           eng_flag;
    logic [7:0]            eng_addr;
    logic                  eng_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic                  host_req;
    logic                  host_gnt;

    modport master (
        input  cmd_valid, cmd_tiles, cmd_simd, cmd_base,
        input  eng_flag, eng_addr, eng_wr_en, host_req,
        output cmd_ready, eng_ctrl, mem_addr, mem_wr_en, host_gnt
    );

    modport slave (
        output cmd_valid, cmd_tiles, cmd_simd, cmd_base,
        output eng_flag, eng_addr, eng_wr_en, host_req,
        input  cmd_ready, eng_ctrl, mem_addr, mem_wr_en, host_gnt
    );
endinterface

// File: rtl/vmx_tile_scheduler.sv
// vmx_tile_scheduler: sequences multi-tile jobs on the vmx_mm_wrapper engine,
// relocates the engine's 8-bit local address into a per-tile BRAM window and
// hands the shared BRAM port to the host between tiles.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  bus          vmx_sched_if.master (cmd_*, eng_*, mem_*, host_*)
//  busy         job in progress
//  done         1-cycle pulse at job end
//  err          1-cycle pulse on reject / engine timeout
//  tile_idx     current tile
//  perf_cycles  busy-cycle counter when VMX_SCHED_PERF_EN is defined, else 0
// Optional feature macro: VMX_SCHED_PERF_EN
module vmx_tile_scheduler #(
    parameter int unsigned MAX_TILES   = 16,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned TILE_STRIDE = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    vmx_sched_if.master                    bus,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(MAX_TILES):0]     tile_idx,
    output logic [31:0]                    perf_cycles
);
    localparam int unsigned TW  = $clog2(MAX_TILES) + 1;
    localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST,
        ST_START,
        ST_RUN,
        ST_NEXT,
        ST_FIN
    } state_t;

    state_t                state_q, state_d;
    state_t                saved_q, saved_d;
    logic [TW-1:0]         tiles_q, tiles_d;
    logic                  simd_q, simd_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [TW-1:0]         tile_idx_q, tile_idx_d;
    logic [TOW-1:0]        tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  rdy_q, rdy_d;
    logic                  host_gnt_q, host_gnt_d;
    logic [31:0]           ctrl_q, ctrl_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  job_start_c;
    logic                  timeout_c;

    // Host has priority over a same-cycle command, so ready must see host_req without a cycle lag.
    assign bus.cmd_ready = rdy_q & ~bus.host_req;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            saved_q    <= ST_IDLE;
            tiles_q    <= '0;
            simd_q     <= 1'b0;
            base_q     <= '0;
            tile_idx_q <= '0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
            host_gnt_q <= 1'b0;
            ctrl_q     <= '0;
            mem_addr_q <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            tiles_q    <= tiles_d;
            simd_q     <= simd_d;
            base_q     <= base_d;
            tile_idx_q <= tile_idx_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
            host_gnt_q <= host_gnt_d;
            ctrl_q     <= ctrl_d;
            mem_addr_q <= mem_addr_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        tiles_d     = tiles_q;
        simd_d      = simd_q;
        base_d      = base_q;
        tile_idx_d  = tile_idx_q;
        tmo_d       = tmo_q + TOW'(1);
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        job_start_c = 1'b0;
        timeout_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.host_req) begin
                    state_d = ST_HOST;
                    saved_d = ST_IDLE;
                end else if (bus.cmd_valid && bus.cmd_ready) begin
                    if (bus.cmd_tiles > TW'(MAX_TILES)) begin
                        err_d = 1'b1;
                    end else begin
                        job_start_c = 1'b1;
                        tiles_d     = bus.cmd_tiles;
                        simd_d      = bus.cmd_simd;
                        base_d      = bus.cmd_base;
                        tile_idx_d  = '0;
                        busy_d      = 1'b1;
                        state_d     = (bus.cmd_tiles == '0) ? ST_FIN : ST_START;
                    end
                end
            end
            ST_HOST: begin
                if (!bus.host_req) begin
                    state_d = saved_q;
                end
            end
            ST_START: begin
                if (bus.eng_flag != '0) begin
                    state_d = ST_RUN;
                end else if (tmo_q == TOW'(TIMEOUT_CYC - 1)) begin
                    timeout_c = 1'b1;
                end
            end
            ST_RUN: begin
                // Advance on leaving RUN so a host detour through NEXT never double-counts.
                if (bus.eng_flag == '0) begin
                    state_d    = ST_NEXT;
                    tile_idx_d = tile_idx_q + TW'(1);
                end else if (tmo_q == TOW'(TIMEOUT_CYC - 1)) begin
                    timeout_c = 1'b1;
                end
            end
            ST_NEXT: begin
                if (tile_idx_q == tiles_q) begin
                    state_d = ST_FIN;
                end else if (bus.host_req) begin
                    state_d = ST_HOST;
                    saved_d = ST_NEXT;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_c) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
        end

        // Phase timer restarts on every state change.
        if (state_d != state_q) begin
            tmo_d = '0;
        end

        rdy_d      = (state_d == ST_IDLE);
        host_gnt_d = (state_d == ST_HOST);
        // Ctrl is held only while waiting in START; dropping it on flag!=0 avoids re-triggering.
        ctrl_d     = (state_d == ST_START) ? {30'b0, simd_d, 1'b1} : 32'b0;
        mem_wr_d   = bus.eng_wr_en & ~host_gnt_d;
        mem_addr_d = base_q
                   + ADDR_WIDTH'(tile_idx_q) * ADDR_WIDTH'(TILE_STRIDE)
                   + ADDR_WIDTH'(bus.eng_addr);
    end

    assign bus.eng_ctrl  = ctrl_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr_en = mem_wr_q;
    assign bus.host_gnt  = host_gnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign tile_idx      = tile_idx_q;

`ifdef VMX_SCHED_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared when a job starts, frozen once busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (job_start_c) begin
            perf_q <= '0;
        end else if (busy_q) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'b0;
`endif

endmodule

// File: tb/tb_vmx_tile_scheduler.sv
// Testbench for vmx_tile_scheduler: stimulus pushes expected ctrl pulses, BRAM
// writes, done and err events into queues; a negedge monitor pops and compares.
module tb_vmx_tile_scheduler;
    localparam int unsigned TW = 5;
    localparam int unsigned AW = 12;
    localparam int ENG_CYC = 10;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [TW-1:0] tile_idx;
    logic [31:0]   perf_cycles;

    vmx_sched_if #(.MAX_TILES(16), .ADDR_WIDTH(AW)) bus ();

    vmx_tile_scheduler #(
        .MAX_TILES(16), .ADDR_WIDTH(AW), .TILE_STRIDE(16), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done),
        .err(err), .tile_idx(tile_idx), .perf_cycles(perf_cycles)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]   q_ctrl[$];
    logic [AW-1:0] q_wr[$];
    logic [TW-1:0] q_done[$];
    bit            q_err[$];

    // engine model controls
    int   eng_off = 0;
    bit   stuck = 0;
    int   trig = 0;
    bit   active = 0;
    int   ecnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event 0x%0h expected none", name, act);
    endtask

    // Engine model: triggers on ctrl[0], holds flag for ENG_CYC cycles writing off+k.
    initial begin
        bus.eng_flag  = '0;
        bus.eng_addr  = '0;
        bus.eng_wr_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                active = 0;
                bus.eng_flag  = '0;
                bus.eng_wr_en = 1'b0;
            end else if (!active) begin
                bus.eng_wr_en = 1'b0;
                if (bus.eng_ctrl[0] && !stuck) begin
                    active = 1;
                    ecnt = 0;
                    trig++;
                    bus.eng_flag  = 32'h1;
                    bus.eng_wr_en = 1'b1;
                    bus.eng_addr  = 8'(eng_off);
                end
            end else begin
                ecnt++;
                if (ecnt < ENG_CYC) begin
                    bus.eng_wr_en = 1'b1;
                    bus.eng_addr  = 8'(eng_off + ecnt);
                end else begin
                    active = 0;
                    bus.eng_flag  = '0;
                    bus.eng_wr_en = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    logic [31:0] prev_ctrl = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.eng_ctrl != '0 && prev_ctrl == '0) begin
                if (q_ctrl.size() == 0) unexpected("ctrl", bus.eng_ctrl);
                else check("ctrl", bus.eng_ctrl, q_ctrl.pop_front());
            end
            if (bus.mem_wr_en) begin
                if (q_wr.size() == 0) unexpected("mem_wr", 32'(bus.mem_addr));
                else check("mem_addr", 32'(bus.mem_addr), 32'(q_wr.pop_front()));
            end
            if (done) begin
                if (q_done.size() == 0) unexpected("done", 32'(tile_idx));
                else check("done_tile_idx", 32'(tile_idx), 32'(q_done.pop_front()));
            end
            if (err) begin
                if (q_err.size() == 0) unexpected("err", 32'(busy));
                else check("err_busy", 32'(busy), 32'(q_err.pop_front()));
            end
        end
        prev_ctrl = bus.eng_ctrl;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int tiles, input bit simd, input int base, input int off);
        logic [AW-1:0] a;
        for (int t = 0; t < tiles; t++) begin
            q_ctrl.push_back({30'b0, simd, 1'b1});
            for (int k = 0; k < ENG_CYC; k++) begin
                a = AW'(base + t * 16 + off + k);
                q_wr.push_back(a);
            end
        end
        q_done.push_back(TW'(tiles));
    endtask

    task automatic drive_cmd(input int tiles, input bit simd, input int base);
        bus.cmd_tiles = TW'(tiles);
        bus.cmd_simd  = simd;
        bus.cmd_base  = AW'(base);
        bus.cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            bus.cmd_valid = 1'b0;
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic wait_end(input string name, input int budget, output int nbusy);
        bit ok = 0;
        nbusy = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) begin
                ok = 1;
                break;
            end
            if (busy) nbusy++;
        end
        if (!ok) check({name, "_end_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_perf(input string name, input int nbusy);
`ifdef VMX_SCHED_PERF_EN
        check(name, perf_cycles, 32'(nbusy));
`else
        check(name, perf_cycles, 32'd0);
`endif
    endtask

    initial begin
        int nb;
        int t0;
        int n;
        bit bad;

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_tiles = '0;
        bus.cmd_simd  = 1'b0;
        bus.cmd_base  = '0;
        bus.host_req  = 1'b0;
        #2;
        check("rst_outputs", {busy, done, err, bus.cmd_ready, bus.host_gnt, bus.mem_wr_en}, 32'd0);
        check("rst_ctrl", bus.eng_ctrl, 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(bus.cmd_ready), 32'd1);

        // 1: three tiles at base 0x100
        eng_off = 0;
        t0 = trig;
        push_job(3, 1'b0, 'h100, 0);
        drive_cmd(3, 1'b0, 'h100);
        wait_accept("t1");
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ctrl_first", bus.eng_ctrl, 32'h1);
        wait_end("t1", 200, nb);
        nb++;
        check("t1_triggers", 32'(trig - t0), 32'd3);
        check("t1_busy_after_done", 32'(busy), 32'd0);
        check_perf("t1_perf", nb);
        tick();

        // 2: host request during tile 1 RUN
        t0 = trig;
        push_job(3, 1'b1, 'h200, 0);
        drive_cmd(3, 1'b1, 'h200);
        wait_accept("t2");
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.eng_flag != '0 && tile_idx == TW'(1)) begin
                bad = 0;
                break;
            end
        end
        check("t2_reach_run1", 32'(bad), 32'd0);
        tick();
        bus.host_req = 1'b1;
        @(negedge clk);
        check("t2_no_gnt_in_run", 32'(bus.host_gnt), 32'd0);
        bad = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.eng_ctrl != '0) break;
            if (bus.host_gnt) begin
                bad = 0;
                break;
            end
        end
        check("t2_gnt_after_run", 32'(bad), 32'd0);
        check("t2_gnt_tile_idx", 32'(tile_idx), 32'd2);
        check("t2_gnt_engine_idle", bus.eng_flag, 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.eng_ctrl != '0 || !bus.host_gnt || bus.cmd_ready) bad = 1;
        end
        check("t2_start_held", 32'(bad), 32'd0);
        tick();
        bus.host_req = 1'b0;
        wait_end("t2", 200, nb);
        check("t2_triggers", 32'(trig - t0), 32'd3);
        tick();

        // 3: host and command in the same IDLE cycle
        push_job(1, 1'b0, 'h300, 0);
        drive_cmd(1, 1'b0, 'h300);
        bus.host_req = 1'b1;
        #1;
        check("t3_ready_low", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("t3_gnt", 32'(bus.host_gnt), 32'd1);
        check("t3_not_busy", 32'(busy), 32'd0);
        tick();
        tick();
        bus.host_req = 1'b0;
        wait_accept("t3");
        check("t3_gnt_released", 32'(bus.host_gnt), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        wait_end("t3", 100, nb);
        tick();

        // 4: engine never answers -> timeout
        stuck = 1;
        q_ctrl.push_back(32'h1);
        q_err.push_back(1'b0);
        drive_cmd(1, 1'b0, 'h000);
        wait_accept("t4");
        n = 0;
        bad = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.eng_ctrl != '0) n++;
            if (err) begin
                bad = 0;
                break;
            end
        end
        check("t4_err_seen", 32'(bad), 32'd0);
        check("t4_ctrl_cycles", 32'(n), 32'd255);
        check("t4_ctrl_cleared", bus.eng_ctrl, 32'd0);
        check("t4_busy_cleared", 32'(busy), 32'd0);
        check("t4_no_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        stuck = 0;

        // 5a: zero tiles
        q_done.push_back('0);
        drive_cmd(0, 1'b0, 'h050);
        wait_accept("t5a");
        @(negedge clk);
        check("t5a_busy", 32'(busy), 32'd1);
        check("t5a_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("t5a_done", 32'(done), 32'd1);
        check("t5a_busy_low", 32'(busy), 32'd0);
        tick();

        // 5b: too many tiles
        q_err.push_back(1'b0);
        drive_cmd(17, 1'b0, 'h050);
        wait_accept("t5b");
        @(negedge clk);
        check("t5b_err", 32'(err), 32'd1);
        check("t5b_no_busy", 32'(busy), 32'd0);
        tick();
        tick();

        // 6a: address wrap, base 0xFF0, tile 1, eng_addr 0x20 -> 0x020
        eng_off = 'h20;
        push_job(2, 1'b0, 'hFF0, 'h20);
        drive_cmd(2, 1'b0, 'hFF0);
        wait_accept("t6a");
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en && tile_idx == TW'(1)) begin
                bad = 0;
                break;
            end
        end
        check("t6a_wrap_addr", 32'(bus.mem_addr), 32'h020);
        check("t6a_wrap_seen", 32'(bad), 32'd0);
        wait_end("t6a", 100, nb);
        tick();

        // 6b: async reset mid-RUN of tile 1
        eng_off = 0;
        push_job(2, 1'b1, 'h400, 0);
        drive_cmd(2, 1'b1, 'h400);
        wait_accept("t6b");
        bad = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.eng_flag != '0 && tile_idx == TW'(1) && bus.mem_wr_en) begin
                bad = 0;
                break;
            end
        end
        check("t6b_reach_run1", 32'(bad), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6b_rst_flags", {busy, done, err, bus.cmd_ready, bus.host_gnt, bus.mem_wr_en}, 32'd0);
        check("t6b_rst_tile_idx", 32'(tile_idx), 32'd0);
        check("t6b_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("t6b_rst_ctrl", bus.eng_ctrl, 32'd0);
        check("t6b_rst_perf", perf_cycles, 32'd0);
        tick();
        tick();
        q_ctrl.delete();
        q_wr.delete();
        q_done.delete();
        q_err.delete();
        rst_n = 1'b1;
        tick();
        check("t6b_idle_after_rst", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) tick();

        check("left_ctrl", 32'(q_ctrl.size()), 32'd0);
        check("left_wr", 32'(q_wr.size()), 32'd0);
        check("left_done", 32'(q_done.size()), 32'd0);
        check("left_err", 32'(q_err.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
